// File: rtl/ifu_fb_pkg.sv
// Shared types and helpers for the fetch-buffer aligner.
package ifu_fb_pkg;

  localparam int HW_PER_BLK = 8;

  typedef struct packed {
    logic [127:0] data;
    logic [31:4]  base;
    logic [2:0]   start;
    logic         valid;
  } fb_entry_t;

  // Compressed instructions are anything whose low two bits are not 2'b11.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ifu_fb_align_if.sv
// F2 write port and the two decode slots of the fetch-buffer aligner.
interface ifu_fb_align_if;
  // Slots present valid independent of accept; a slot transfers in the cycle
  // where valid & accept are both high. F2 writes have no back-pressure.
  logic          ifu_fetch_val_f2;
  logic [31:1]   ifu_fetch_addr_f2;
  logic [127:0]  ifu_fetch_data_f2;
  logic          dec_i0_accept;
  logic          dec_i1_accept;
  logic          ifu_i0_valid;
  logic          ifu_i1_valid;
  logic [31:0]   ifu_i0_instr;
  logic [31:0]   ifu_i1_instr;
  logic [31:1]   ifu_i0_pc;
  logic [31:1]   ifu_i1_pc;
  logic          ifu_i0_pc4;
  logic          ifu_i1_pc4;

  modport master (
    output ifu_fetch_val_f2, ifu_fetch_addr_f2, ifu_fetch_data_f2,
    output dec_i0_accept, dec_i1_accept,
    input  ifu_i0_valid, ifu_i1_valid, ifu_i0_instr, ifu_i1_instr,
    input  ifu_i0_pc, ifu_i1_pc, ifu_i0_pc4, ifu_i1_pc4
  );

  modport slave (
    input  ifu_fetch_val_f2, ifu_fetch_addr_f2, ifu_fetch_data_f2,
    input  dec_i0_accept, dec_i1_accept,
    output ifu_i0_valid, ifu_i1_valid, ifu_i0_instr, ifu_i1_instr,
    output ifu_i0_pc, ifu_i1_pc, ifu_i0_pc4, ifu_i1_pc4
  );
endinterface

// File: rtl/ifu_fb_slot_dec.sv
// Splits a 4-halfword window into up to two RVC/32-bit instructions.
module ifu_fb_slot_dec
  import ifu_fb_pkg::*;
(
  input  logic [3:0][15:0] win_hw,
  input  logic [3:0]       win_hv,
  output logic             i0_valid,
  output logic             i0_len2,
  output logic [31:0]      i0_instr,
  output logic             i1_valid,
  output logic             i1_len2,
  output logic [31:0]      i1_instr
);

  logic [15:0] i1_lo, i1_hi;
  logic        i1_lo_v, i1_hi_v;

  always_comb begin
    i0_len2  = ~is_rvc(win_hw[0]);
    i0_valid = win_hv[0] & (~i0_len2 | win_hv[1]);
    i0_instr = i0_len2 ? {win_hw[1], win_hw[0]} : {16'h0, win_hw[0]};

    // i1 begins right after i0, at window position 1 or 2.
    i1_lo    = i0_len2 ? win_hw[2] : win_hw[1];
    i1_hi    = i0_len2 ? win_hw[3] : win_hw[2];
    i1_lo_v  = i0_len2 ? win_hv[2] : win_hv[1];
    i1_hi_v  = i0_len2 ? win_hv[3] : win_hv[2];

    i1_len2  = ~is_rvc(i1_lo);
    i1_valid = i0_valid & i1_lo_v & (~i1_len2 | i1_hi_v);
    i1_instr = i1_len2 ? {i1_hi, i1_lo} : {16'h0, i1_lo};
  end

endmodule

// File: rtl/ifu_fb_align.sv
// Fetch-buffer queue plus two-wide instruction aligner feeding decode.
module ifu_fb_align
  import ifu_fb_pkg::*;
#(
  parameter int NUM_FB = 4
)
(
  input  logic          clk,
  input  logic          rst_l,
  input  logic          exu_flush_final,
  ifu_fb_align_if.slave fb,
  output logic          ifu_fb_consume1,
  output logic          ifu_fb_consume2,
  output logic          ifu_fb_empty,
  output logic          ifu_fb_overflow_err
);

  localparam int IW = $clog2(NUM_FB);
  localparam int CW = IW + 1;

  fb_entry_t         fb_q [NUM_FB];
  logic [IW-1:0]     head_q, tail_q, head1, head2, head_nxt;
  logic [CW-1:0]     count_q;
  logic [2:0]        off_q, off_nxt;

  logic [127:0]      h_data;
  logic [31:4]       h_base;
  logic              h_valid;
  fb_entry_t         e1;

  logic [3:0][15:0]  win_hw;
  logic [3:0]        win_hv, win_nxt;
  logic [3:0][2:0]   win_idx;
  logic [3:0]        pos_h, pos_n;

  logic              i0_v, i0_len2, i1_v, i1_len2;
  logic [31:0]       i0_instr, i1_instr;
  logic [1:0]        i1_pos;

  logic              full, wr_en, acc0, acc1, free_head, free_both;
  logic [2:0]        n_hw;
  logic [3:0]        used, pos1;
  logic [1:0]        freed;

  assign head1   = head_q + IW'(1);
  assign head2   = head_q + IW'(2);
  assign h_data  = fb_q[head_q].data;
  assign h_base  = fb_q[head_q].base;
  assign h_valid = fb_q[head_q].valid;
  assign e1      = fb_q[head1];

  // Window: head from the current offset, then head+1 from its own start.
  always_comb begin
    win_hw  = '0;
    win_hv  = '0;
    win_idx = '0;
    win_nxt = '0;
    pos_h   = '0;
    pos_n   = '0;
    for (int j = 0; j < 4; j++) begin
      pos_h = {1'b0, off_q} + 4'(j);
      pos_n = {1'b0, e1.start} + (pos_h - 4'd8);
      if (!pos_h[3]) begin
        win_idx[j] = pos_h[2:0];
        win_hv[j]  = h_valid;
        win_hw[j]  = h_data[{pos_h[2:0], 4'b0000} +: 16];
      end else begin
        win_nxt[j] = 1'b1;
        win_idx[j] = pos_n[2:0];
        win_hv[j]  = e1.valid & ~pos_n[3];
        win_hw[j]  = e1.data[{pos_n[2:0], 4'b0000} +: 16];
      end
    end
  end

  ifu_fb_slot_dec u_slot_dec (
    .win_hw   (win_hw),
    .win_hv   (win_hv),
    .i0_valid (i0_v),
    .i0_len2  (i0_len2),
    .i0_instr (i0_instr),
    .i1_valid (i1_v),
    .i1_len2  (i1_len2),
    .i1_instr (i1_instr)
  );

  assign i1_pos = i0_len2 ? 2'd2 : 2'd1;

  always_comb begin
    fb.ifu_i0_valid = i0_v & ~exu_flush_final;
    fb.ifu_i1_valid = i1_v & ~exu_flush_final;
    fb.ifu_i0_instr = fb.ifu_i0_valid ? i0_instr : 32'h0;
    fb.ifu_i1_instr = fb.ifu_i1_valid ? i1_instr : 32'h0;
    fb.ifu_i0_pc4   = fb.ifu_i0_valid & i0_len2;
    fb.ifu_i1_pc4   = fb.ifu_i1_valid & i1_len2;
    fb.ifu_i0_pc    = fb.ifu_i0_valid ? {h_base, win_idx[0]} : 31'h0;
    fb.ifu_i1_pc    = '0;
    if (fb.ifu_i1_valid)
      fb.ifu_i1_pc = {(win_nxt[i1_pos] ? e1.base : h_base), win_idx[i1_pos]};
  end

  // Consumption and head/offset advance.
  always_comb begin
    acc0 = fb.dec_i0_accept & fb.ifu_i0_valid;
    acc1 = acc0 & fb.dec_i1_accept & fb.ifu_i1_valid;
    n_hw = '0;
    if (acc0)
      n_hw = (i0_len2 ? 3'd2 : 3'd1) + (acc1 ? (i1_len2 ? 3'd2 : 3'd1) : 3'd0);
    used      = {1'b0, off_q} + {1'b0, n_hw};
    pos1      = {1'b0, e1.start} + (used - 4'd8);
    free_head = used[3];
    free_both = free_head & pos1[3];
    freed     = free_both ? 2'd2 : (free_head ? 2'd1 : 2'd0);
    head_nxt  = head_q + IW'(freed);

    full  = count_q == CW'(NUM_FB);
    wr_en = fb.ifu_fetch_val_f2 & ~exu_flush_final & ~full;

    off_nxt = used[2:0];
    if (free_both)      off_nxt = fb_q[head2].start;
    else if (free_head) off_nxt = pos1[2:0];
    // A block landing in an otherwise empty queue becomes the head.
    if (wr_en && tail_q == head_nxt) off_nxt = fb.ifu_fetch_addr_f2[3:1];
  end

  assign ifu_fb_consume1     = free_head & ~free_both;
  assign ifu_fb_consume2     = free_both;
  assign ifu_fb_empty        = count_q == '0;
  assign ifu_fb_overflow_err = fb.ifu_fetch_val_f2 & ~exu_flush_final & full;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NUM_FB; i++) fb_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      off_q   <= '0;
    end else if (exu_flush_final) begin
      for (int i = 0; i < NUM_FB; i++) fb_q[i].valid <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      off_q   <= '0;
    end else begin
      if (wr_en) begin
        fb_q[tail_q] <= '{data:  fb.ifu_fetch_data_f2,
                          base:  fb.ifu_fetch_addr_f2[31:4],
                          start: fb.ifu_fetch_addr_f2[3:1],
                          valid: 1'b1};
        tail_q <= tail_q + IW'(1);
      end
      if (free_head) fb_q[head_q].valid <= 1'b0;
      if (free_both) fb_q[head1].valid  <= 1'b0;
      head_q  <= head_nxt;
      count_q <= count_q + CW'(wr_en) - CW'(freed);
      off_q   <= off_nxt;
    end
  end

endmodule

// File: doc/ifu_fb_align.md
Name: ifu_fb_align

Overview:
- Consumer end of the fetch pipe. Accepts F2 fetch blocks that hit: 16 bytes each, 16-byte aligned, possibly entered mid-block. Holds them in a small fetch-buffer queue.
- Aligns up to two RISC-V instructions (16/32-bit) per cycle toward decode.
- Returns `ifu_fb_consume1` / `ifu_fb_consume2` to fetch control, which uses them to mass-balance its fetch-buffer occupancy model.
- Sits between the I-cache F2 data return and the decode instruction buffer.

Parameters:
- `NUM_FB`, 4, fetch-buffer entries (power of 2, ≥2).

Ports:
- `clk`  in  1  core clock
- `rst_l`  in  1  async active-low reset
- `exu_flush_final`  in  1  flush: empty all buffers
- `ifu_fetch_val_f2`  in  1  valid F2 block (request & cache hit)
- `ifu_fetch_addr_f2`  in  31  fetch addr [31:1]; [3:1] = first valid halfword
- `ifu_fetch_data_f2`  in  128  block data, halfword k at [16k+15:16k]
- `dec_i0_accept`  in  1  decode takes slot 0
- `dec_i1_accept`  in  1  decode takes slot 1 (only honoured with `dec_i0_accept`)
- `ifu_i0_valid`, `ifu_i1_valid`  out  1  slot valid
- `ifu_i0_instr`, `ifu_i1_instr`  out  32  instruction; 16-bit zero-extended
- `ifu_i0_pc`, `ifu_i1_pc`  out  31  PC [31:1]
- `ifu_i0_pc4`, `ifu_i1_pc4`  out  1  1 = 32-bit instruction
- `ifu_fb_consume1`  out  1  exactly one entry freed this cycle
- `ifu_fb_consume2`  out  1  two entries freed this cycle
- `ifu_fb_empty`  out  1  no valid entries
- `ifu_fb_overflow_err`  out  1  pulse: write dropped, queue full

Behaviour:
- Reset: all entries invalid; head = tail = 0; halfword offset = 0; all outputs 0 except `ifu_fb_empty` = 1.
- Entry contents: data[127:0], base[31:4], start[2:0], valid.
- Write:
  - `ifu_fetch_val_f2` & ~flush & ~full writes at tail, start = addr[3:1]; tail++ (mod `NUM_FB`).
  - When head is the entry being written, the offset loads start.
  - Written data is visible to the aligner the next cycle; there is no bypass.
- Full on write: data dropped; `ifu_fb_overflow_err` = 1 for that cycle. This is an illegal condition; the fetch-control model must prevent it.
- Window: 4 halfwords starting at head[offset], continuing into head+1 from its start. A halfword is valid only if its entry is valid.
- Slot decode:
  - i0 at window hw0: length 2 if hw0[1:0] == 2'b11, else 1. Valid only if all its halfwords are valid.
  - i1 starts at hw(len0), same rules; requires i0 valid.
  - PC = base of the entry holding the instruction's first halfword, concatenated with that halfword's index.
  - A 32-bit instruction may straddle head and head+1.
- Consume on accept:
  - Consumed halfwords = len0 (+ len1 if `dec_i1_accept`).
  - Advance offset; free head if its last halfword (index 7) is consumed. Free head+1 too if the consumption reaches its index 7.
  - The new offset is the next entry's start plus any remainder.
  - `consume1` / `consume2` are combinational, same cycle as the accept; they are never both 1.
- Accept of an invalid slot: ignored. Accepting i1 without i0: ignored.
- Simultaneous write and consume: both take effect; count = count + w − freed.
- Flush: all entries invalid, head = tail = 0 next cycle. The same-cycle write is dropped. Slot valids and consumes are forced to 0 in the flush cycle.
- Reset mid-operation: immediate async clear to reset values.
- Wrap: head and tail indices wrap mod `NUM_FB`. Count is held separately (width `$clog2(NUM_FB)+1`) to distinguish full from empty.

Decomposition:
- Package `ifu_fb_pkg`: `fb_entry_t` struct (data, base, start, valid), `HW_PER_BLK = 8`, function `is_rvc(hw)`.
- Sub-module `ifu_fb_slot_dec`: combinational; window of 4 halfwords + valids in → i0/i1 valid, length, instr out.

Test Plan:
1. Reset, write block addr 0x0000_1000 >> 1 with eight 16-bit C.NOPs (0x0001) → cycle +1: i0/i1 valid, pc 0x800/0x801 ([31:1]), pc4 = 0. After 4 double-accepts: `consume1` = 1 on the 4th; `ifu_fb_empty` = 1.
2. Block A: hw7 = 0x0013 (low half of 32-bit). Block B: hw0 = 0x0000. Accept → i0 instr 0x0000_0013, pc4 = 1, pc = A.base|7; `consume1` = 1.
3. Block A entered at addr[3:1] = 7 (one 16-bit instruction). Block B at [3:1] = 6 holding two 16-bit instructions. Accept i0 + i1 → `consume1` = 1 (A freed, B not yet: offset 7 remains).
4. Fill `NUM_FB` = 4 entries, write a 5th → `ifu_fb_overflow_err` pulses, contents unchanged.
5. Flush coincident with write and accept → next cycle `ifu_fb_empty` = 1, no consume asserted, written block absent.
6. Assert `rst_l` low mid-stream with 3 entries valid → outputs return to reset values asynchronously.
